// File: rtl/ls_addr_seq_if.sv
// Command and address-bus bundle between a burst issuer, the load/store
// address sequencer and the downstream load/store address mux.
interface ls_addr_seq_if #(
    parameter int A = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_op;
    logic [A-1:0] cmd_base;
    logic [A-1:0] cmd_len;
    logic [A-1:0] wr_addr;
    logic [A-1:0] rd_addr;
    logic         sel;
    logic         addr_valid;
    logic         addr_ready;
    logic         busy;
    logic         done;

    // master: the sequencer, which drives the address side
    modport master (
        input  cmd_valid, cmd_op, cmd_base, cmd_len, addr_ready,
        output cmd_ready, wr_addr, rd_addr, sel, addr_valid, busy, done
    );

    // slave: the command issuer / address consumer
    modport slave (
        output cmd_valid, cmd_op, cmd_base, cmd_len, addr_ready,
        input  cmd_ready, wr_addr, rd_addr, sel, addr_valid, busy, done
    );
endinterface

// File: rtl/ls_addr_seq.sv
// Load/store address sequencer: takes one burst command and walks its addresses
// one beat per accepted cycle, feeding the 1-of-2 load/store address mux.
module ls_addr_seq #(
    parameter int A = 8,
    parameter int D = 8,
    parameter int R = 256
) (
    input  logic          clk,
    input  logic          rst,
    ls_addr_seq_if.master bus
);
    // D only matters to neighbours sharing the RAM port; R must match 2^A
    // because the address wrap relies on A-bit truncation.
    if (R != (1 << A) || D < 1) begin : g_param_chk
        $error("ls_addr_seq: R must equal 2**A and D must be positive");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e       state_q;
    logic [A-1:0] cnt_q, len_q;
    logic [A-1:0] wr_addr_q, rd_addr_q;
    logic         sel_q, cmd_ready_q, addr_valid_q, busy_q, done_q;
    logic         accept_d, beat_d, last_d;

    assign accept_d = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;
    assign beat_d   = (state_q == RUN) && addr_valid_q && bus.addr_ready;
    assign last_d   = (cnt_q == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            sel_q        <= 1'b0;
            cmd_ready_q  <= 1'b1;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        len_q        <= bus.cmd_len;
                        cnt_q        <= '0;
                        sel_q        <= bus.cmd_op;
                        if (bus.cmd_op) wr_addr_q <= bus.cmd_base;
                        else            rd_addr_q <= bus.cmd_base;
                        cmd_ready_q  <= 1'b0;
                        addr_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    if (beat_d) begin
                        if (last_d) begin
                            addr_valid_q <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (sel_q) wr_addr_q <= wr_addr_q + 1'b1;
                            else       rd_addr_q <= rd_addr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q      <= IDLE;
                    cmd_ready_q  <= 1'b1;
                    addr_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.sel        = sel_q;
    assign bus.addr_valid = addr_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_ls_addr_seq.sv
// Directed bench for ls_addr_seq: reset, store/load bursts, wrap, stall,
// ignored command during a burst, and reset mid-burst.
module tb_ls_addr_seq;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ls_addr_seq_if #(.A(8)) bus ();

    ls_addr_seq #(.A(8), .D(8), .R(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] wr, input logic [7:0] rd,
                            input logic sl);
        chk({tag, ".cmd_ready"},  32'(bus.cmd_ready),  32'(1));
        chk({tag, ".addr_valid"}, 32'(bus.addr_valid), 32'(0));
        chk({tag, ".busy"},       32'(bus.busy),       32'(0));
        chk({tag, ".done"},       32'(bus.done),       32'(0));
        chk({tag, ".wr_addr"},    32'(bus.wr_addr),    32'(wr));
        chk({tag, ".rd_addr"},    32'(bus.rd_addr),    32'(rd));
        chk({tag, ".sel"},        32'(bus.sel),        32'(sl));
    endtask

    // Called at a negedge; command is taken on the next posedge.
    task automatic issue(input logic op, input logic [7:0] base, input logic [7:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input logic op, input logic [7:0] addr,
                            input logic [7:0] other);
        chk({tag, ".addr_valid"}, 32'(bus.addr_valid), 32'(1));
        chk({tag, ".busy"},       32'(bus.busy),       32'(1));
        chk({tag, ".cmd_ready"},  32'(bus.cmd_ready),  32'(0));
        chk({tag, ".done"},       32'(bus.done),       32'(0));
        chk({tag, ".sel"},        32'(bus.sel),        32'(op));
        chk({tag, ".act"},  32'(op ? bus.wr_addr : bus.rd_addr), 32'(addr));
        chk({tag, ".oth"},  32'(op ? bus.rd_addr : bus.wr_addr), 32'(other));
    endtask

    task automatic chk_done(input string tag);
        chk({tag, ".done"},       32'(bus.done),       32'(1));
        chk({tag, ".busy"},       32'(bus.busy),       32'(1));
        chk({tag, ".addr_valid"}, 32'(bus.addr_valid), 32'(0));
        chk({tag, ".cmd_ready"},  32'(bus.cmd_ready),  32'(0));
    endtask

    // Expected addresses given as explicit hand-written vectors.
    logic [7:0] st_vec [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [7:0] ld_vec [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [7:0] ig_vec [4] = '{8'h20, 8'h21, 8'h22, 8'h23};

    initial begin
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 1'b0;
        bus.cmd_base   = 8'h00;
        bus.cmd_len    = 8'h00;
        bus.addr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset", 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
        bus.addr_ready = 1'b1;

        // store burst 0x10..0x13
        issue(1'b1, 8'h10, 8'd3);
        for (int i = 0; i < 4; i++) begin
            chk_beat($sformatf("st%0d", i), 1'b1, st_vec[i], 8'h00);
            @(negedge clk);
        end
        chk_done("st_done");
        @(negedge clk);
        chk_idle("st_idle", 8'h13, 8'h00, 1'b1);

        // load burst with wrap, wr_addr holds 0x13
        issue(1'b0, 8'hFE, 8'd3);
        for (int i = 0; i < 4; i++) begin
            chk_beat($sformatf("ld%0d", i), 1'b0, ld_vec[i], 8'h13);
            @(negedge clk);
        end
        chk_done("ld_done");
        @(negedge clk);
        chk_idle("ld_idle", 8'h13, 8'h01, 1'b0);

        // store burst with 3-cycle stall on beat 1
        issue(1'b1, 8'h40, 8'd2);
        chk_beat("sst0", 1'b1, 8'h40, 8'h01);
        @(negedge clk);
        chk_beat("sst1", 1'b1, 8'h41, 8'h01);
        bus.addr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_beat($sformatf("stall%0d", i), 1'b1, 8'h41, 8'h01);
        end
        bus.addr_ready = 1'b1;
        @(negedge clk);
        chk_beat("sst2", 1'b1, 8'h42, 8'h01);
        @(negedge clk);
        chk_done("sst_done");
        @(negedge clk);
        chk_idle("sst_idle", 8'h42, 8'h01, 1'b1);

        // cmd_valid during RUN must be ignored
        issue(1'b0, 8'h20, 8'd3);
        for (int i = 0; i < 4; i++) begin
            chk_beat($sformatf("ig%0d", i), 1'b0, ig_vec[i], 8'h42);
            if (i == 1) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 1'b1;
                bus.cmd_base  = 8'h80;
                bus.cmd_len   = 8'd0;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        chk_done("ig_done");
        @(negedge clk);
        chk_idle("ig_idle", 8'h42, 8'h23, 1'b0);

        // reset at beat 2 of a len=7 load
        issue(1'b0, 8'h30, 8'd7);
        chk_beat("rb0", 1'b0, 8'h30, 8'h42);
        @(negedge clk);
        chk_beat("rb1", 1'b0, 8'h31, 8'h42);
        @(negedge clk);
        chk_beat("rb2", 1'b0, 8'h32, 8'h42);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("rst_mid", 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        chk_idle("rst_after", 8'h00, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
